// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency-meter display path.
// Segment codes are gfedcba, active-high; the pin helper adds dp and inverts.
package freq_meter_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;
  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = 3'd5;

  localparam seg7_t SEG_0    = 7'h3F;
  localparam seg7_t SEG_1    = 7'h06;
  localparam seg7_t SEG_2    = 7'h5B;
  localparam seg7_t SEG_3    = 7'h4F;
  localparam seg7_t SEG_4    = 7'h66;
  localparam seg7_t SEG_5    = 7'h6D;
  localparam seg7_t SEG_6    = 7'h7D;
  localparam seg7_t SEG_7    = 7'h07;
  localparam seg7_t SEG_8    = 7'h7F;
  localparam seg7_t SEG_9    = 7'h6F;
  localparam seg7_t SEG_E    = 7'h79;
  localparam seg7_t SEG_DASH = 7'h40;
  localparam seg7_t SEG_OFF  = 7'h00;

  // Pin order is {dp,g,f,e,d,c,b,a}, active-low, with dp held off.
  function automatic logic [7:0] seg_pins(input seg7_t code);
    return {1'b1, ~code};
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high gfedcba output.
// Non-decimal nibbles decode to "E".
module bcd_to_seg7
  import freq_meter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg7
);

  always_comb begin
    case (bcd)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed LED driver: latches a BCD count, scans one digit per
// slot with a short blanking gap, suppresses leading zeros, shows dashes on overflow.
module bcd_display_scan
  import freq_meter_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 2
) (
  input  logic        clk_2,
  input  logic        Rst_n,
  input  logic        latch,
  input  logic [23:0] data,
  input  logic        ovf,
  output logic [7:0]  seg,
  output logic [5:0]  dig
);

  localparam int              PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   BLANK_P  = PW'(BLANK);

  logic [PW-1:0]   prescaler_q;
  digit_idx_t      index_q;
  logic [23:0]     shown_q;
  logic            ovf_q;

  bcd_t            nibble;
  seg7_t           dec_code;
  seg7_t           seg_code;
  logic [5:0]      dig_sel;
  logic [5:0]      lz_mask;
  logic            upper_zero;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_2 or negedge Rst_n) begin
    if (!Rst_n) begin
      prescaler_q <= '0;
      index_q     <= '0;
    end else if (prescaler_q == PRE_LAST) begin
      prescaler_q <= '0;
      index_q     <= (index_q == LAST_DIGIT) ? '0 : index_q + 3'd1;
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
    end
  end

  // Capture is independent of the scan so a latch never disturbs slot timing.
  always_ff @(posedge clk_2 or negedge Rst_n) begin
    if (!Rst_n) begin
      shown_q <= '0;
      ovf_q   <= 1'b0;
    end else if (latch) begin
      shown_q <= data;
      ovf_q   <= ovf;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    nibble = shown_q[3:0];
    case (index_q)
      3'd1:    nibble = shown_q[7:4];
      3'd2:    nibble = shown_q[11:8];
      3'd3:    nibble = shown_q[15:12];
      3'd4:    nibble = shown_q[19:16];
      3'd5:    nibble = shown_q[23:20];
      default: nibble = shown_q[3:0];
    endcase
  end

  // Digit i (i>0) is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (shown_q[4*i +: 4] == 4'd0);
      lz_mask[i] = upper_zero;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd  (nibble),
    .seg7 (dec_code)
  );

  always_comb begin
    dig_sel  = 6'(1) << index_q;
    seg_code = dec_code;
    if (ovf_q) begin
      seg_code = SEG_DASH;
    end else if (|(lz_mask & dig_sel)) begin
      seg_code = SEG_OFF;
    end
  end

  always_ff @(posedge clk_2 or negedge Rst_n) begin
    if (!Rst_n) begin
      seg <= seg_pins(SEG_OFF);
      dig <= '1;
    end else if (prescaler_q < BLANK_P) begin
      seg <= seg_pins(SEG_OFF);
      dig <= '1;
    end else begin
      seg <= seg_pins(seg_code);
      dig <= ~dig_sel;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with SCAN_DIV=8, BLANK=2: checks every
// output cycle of whole scan frames against hand-computed per-digit patterns.
module tb_bcd_display_scan;

  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int SLOTS    = 6;

  logic        clk_2 = 1'b0;
  logic        Rst_n = 1'b1;
  logic        latch = 1'b0;
  logic [23:0] data  = '0;
  logic        ovf   = 1'b0;
  logic [7:0]  seg;
  logic [5:0]  dig;

  int checks = 0;
  int errors = 0;
  int edges;

  always #5 clk_2 = ~clk_2;

  bcd_display_scan #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK)
  ) dut (
    .clk_2 (clk_2),
    .Rst_n (Rst_n),
    .latch (latch),
    .data  (data),
    .ovf   (ovf),
    .seg   (seg),
    .dig   (dig)
  );

  // Edges since reset release: edges % SCAN_DIV is the prescaler phase.
  always @(posedge clk_2 or negedge Rst_n) begin
    if (!Rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected seg byte for digit i lives in exp_seg[8*i +: 8]. Call at a negedge
  // where edges % SCAN_DIV == 0; the next output cycle is a slot's first.
  task automatic scan_window(input string name, input logic [47:0] exp_seg);
    int         slot0;
    int         s;
    logic [5:0] exp_dig;
    logic [7:0] exp_s;
    slot0 = (edges / SCAN_DIV) % SLOTS;
    for (int k = 0; k < SCAN_DIV * SLOTS; k++) begin
      @(negedge clk_2);
      s = (slot0 + k / SCAN_DIV) % SLOTS;
      if ((k % SCAN_DIV) < BLANK) begin
        exp_dig = 6'h3F;
        exp_s   = 8'hFF;
      end else begin
        exp_dig = ~(6'b1 << s);
        exp_s   = exp_seg[8*s +: 8];
      end
      check($sformatf("%s dig k=%0d", name, k), 32'(dig), 32'(exp_dig));
      check($sformatf("%s seg k=%0d", name, k), 32'(seg), 32'(exp_s));
    end
  endtask

  // Wait (bounded) for a negedge at the given phase, and slot when slot >= 0.
  task automatic wait_phase(input int slot, input int pos);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if ((edges % SCAN_DIV) == pos && (slot < 0 || ((edges / SCAN_DIV) % SLOTS) == slot))
        found = 1'b1;
      else
        @(negedge clk_2);
    end
    check($sformatf("wait slot %0d pos %0d", slot, pos), 32'(found), 32'd1);
  endtask

  // One-cycle latch strobe; afterwards the inputs carry junk that must be ignored.
  task automatic do_latch(input logic [23:0] d, input logic o);
    latch = 1'b1;
    data  = d;
    ovf   = o;
    @(negedge clk_2);
    latch = 1'b0;
    data  = 24'h999999;
    ovf   = 1'b1;
  endtask

  initial begin
    #2 Rst_n = 1'b0;
    #1;
    check("reset seg", 32'(seg), 32'hFF);
    check("reset dig", 32'(dig), 32'h3F);
    repeat (2) @(negedge clk_2);
    Rst_n = 1'b1;
    scan_window("after reset", 48'hFF_FF_FF_FF_FF_C0);

    @(negedge clk_2);
    do_latch(24'h012345, 1'b0);
    wait_phase(-1, 0);
    scan_window("012345", 48'hFF_F9_A4_B0_99_92);
    scan_window("012345 hold", 48'hFF_F9_A4_B0_99_92);

    do_latch(24'h00A007, 1'b0);
    wait_phase(-1, 0);
    scan_window("00A007", 48'hFF_FF_86_C0_C0_F8);

    do_latch(24'h123456, 1'b1);
    wait_phase(-1, 0);
    scan_window("overflow", 48'hBF_BF_BF_BF_BF_BF);

    do_latch(24'h000009, 1'b0);
    wait_phase(-1, 0);
    scan_window("000009", 48'hFF_FF_FF_FF_FF_90);

    wait_phase(-1, SCAN_DIV - 1);
    do_latch(24'h987654, 1'b0);
    wait_phase(-1, 0);
    scan_window("latch at tc", 48'h90_80_F8_82_92_99);

    wait_phase(3, 4);
    check("pre-reset dig slot 3", 32'(dig), 32'h37);
    Rst_n = 1'b0;
    #1;
    check("mid-slot reset seg", 32'(seg), 32'hFF);
    check("mid-slot reset dig", 32'(dig), 32'h3F);
    repeat (3) @(negedge clk_2);
    Rst_n = 1'b1;
    scan_window("restart", 48'hFF_FF_FF_FF_FF_C0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk_2 cycles per digit slot; legal range BLANK+2 .. 2^20.
REQ-002 SHALL have parameter BLANK, default 2: cycles at the start of each slot with all digits off (anti-ghosting); legal range 0 .. SCAN_DIV-2.
REQ-003 SHALL have port clk_2  in  1  system clock.
REQ-004 SHALL have port Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port latch  in  1  one-cycle strobe: capture data and ovf.
REQ-006 SHALL have port data  in  24  six packed BCD digits; [3:0] is the least significant digit.
REQ-007 SHALL have port ovf  in  1  counter-chain carry out; high means the count exceeded 999999.
REQ-008 SHALL have port seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dig  out  6  digit enables, active-low, one-hot; dig[0] drives the least significant digit.

Function
REQ-010 SHALL load data into a 24-bit shown register and ovf into a sticky overflow flag on any clk_2 edge where latch=1.
REQ-011 SHALL hold the shown register and overflow flag unchanged while latch=0.
REQ-012 SHALL clear the overflow flag only on a latch where ovf=0.
REQ-013 SHALL run a prescaler that counts 0..SCAN_DIV-1 and wraps.
REQ-014 SHALL advance the digit index 0->1->..->5->0 on the prescaler terminal count.
REQ-015 SHALL register seg and dig, so outputs reflect index, prescaler and shown values with one cycle of latency.
REQ-016 SHALL drive dig=6'b111111 and seg=8'hFF while prescaler < BLANK.
REQ-017 SHALL otherwise drive dig with bit[index]=0 and all other bits 1.
REQ-018 SHALL decode the selected nibble to segments using gfedcba active-high codes 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, then invert for output; dp is always off.
REQ-019 SHALL display nibble values 10..15 as "E" (code 79).
REQ-020 SHALL blank leading zeros: digit i>0 shows all segments off when digits i..5 are all zero; digit 0 always shows.
REQ-021 SHALL, when the overflow flag is set, display "-" (code 40, g only) on all six digits, overriding REQ-018..020.
REQ-022 SHALL give latch priority when it coincides with a slot change: the new slot shows the newly latched value.
REQ-023 SHALL NOT let latch reset or disturb the prescaler or the digit index.

Reset
REQ-024 SHALL, while Rst_n=0, force prescaler=0, index=0, shown=0, overflow flag=0, seg=8'hFF and dig=6'b111111.
REQ-025 SHALL, on the first edge after reset is released, start slot 0 with blanking per REQ-016.
REQ-026 SHALL, when reset is asserted mid-slot, take effect immediately, with no glitch beyond the asynchronous clear.

Structure
REQ-027 SHALL place the segment code constants (digits 0..9, E, dash, all-off) in shared package freq_meter_pkg.
REQ-028 SHALL implement the decode in combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-high out), instantiated once on the muxed nibble.
REQ-029 SHALL compute the leading-zero mask combinationally from the shown register.
REQ-030 SHALL keep the prescaler width at $clog2(SCAN_DIV).

Verification (bench: SCAN_DIV=8, BLANK=2)
REQ-031 Reset, then release -> seg=FF and dig=3F for 2 cycles, then dig=3E (active-low one-hot on digit 0) and seg=~3F ("0"); dig[5:1] never go low during this, all digits above 0 blanked.
REQ-032 Latch data=24'h012345 with ovf=0 -> over 48 cycles the digits show 5,4,3,2,1 on dig[0..4]; dig[5] slot shows seg=FF (leading zero blanked).
REQ-033 Latch data=24'h00A007 -> digit 3 shows "E" (~79), digits 2..0 show 0,0,7, digits 5..4 are blanked.
REQ-034 Latch with ovf=1 -> all slots show ~40 ("-"); a later latch of 24'h000009 with ovf=0 -> digit 0 shows "9" and the rest are blanked.
REQ-035 Assert latch on the same edge as the prescaler terminal count -> the next slot shows the new value; the index sequence is unbroken.
REQ-036 Assert Rst_n=0 mid-slot 3 -> outputs go FF/3F immediately; after release the scan restarts at slot 0 and shown=0.
